timer_counter: RTL and testbench

Parametrised, runtime-programmable timer/counter. Successor to the fixed-function free-running counter.
- Adds a runtime prescaler, runtime top value, and up/down/up-down modes.
- Adds one-shot operation, synchronous load, and compare-match with PWM output.
- Serves as the general timer channel behind peripheral register blocks: periodic interrupts, timeouts and PWM generation.

---
 rtl/timer_counter.sv | 146 ++++++++++++++
 tb/tb_timer_counter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// Runtime-programmable timer/counter: prescaled up/down/up-down counting,
// one-shot or periodic, synchronous load, compare match and PWM output.
module timer_counter #(
  parameter int WIDTH          = 16,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      halt,
  input  logic [1:0]                mode,
  input  logic                      one_shot,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic [WIDTH-1:0]          top,
  input  logic [WIDTH-1:0]          compare,
  input  logic                      load,
  input  logic [WIDTH-1:0]          load_value,
  output logic [WIDTH-1:0]          value,
  output logic                      direction,
  output logic                      running,
  output logic                      wrap,
  output logic                      match,
  output logic                      pwm
);

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_UPDOWN = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_t;

  logic [PRESCALE_WIDTH-1:0] p, p_n;
  logic [WIDTH-1:0]          value_n;
  logic                      done, done_n;
  logic                      dir_reg, dir_n;
  logic                      wrap_n, match_n, pwm_n, direction_n;
  logic                      step;
  mode_t                     mode_e;

  assign mode_e  = mode_t'(mode);
  assign running = enable && !done;

  always_comb begin
    value_n = value;
    p_n     = p;
    done_n  = done;
    dir_n   = dir_reg;
    wrap_n  = 1'b0;
    match_n = 1'b0;
    step    = 1'b0;

    if (load) begin
      value_n = load_value;
      p_n     = '0;
      done_n  = 1'b0;
      dir_n   = 1'b1;
    end else if (halt) begin
      value_n = value;
    end else if (!enable) begin
      p_n    = '0;
      done_n = 1'b0;
    end else if (!done) begin
      // Equality (not >=) so a prescale lowered below p runs p out to all-ones
      if (p == prescale) begin
        p_n  = '0;
        step = 1'b1;
      end else begin
        p_n = p + 1'b1;
      end
    end

    if (step) begin
      case (mode_e)
        MODE_DOWN: begin
          if (value == '0) begin
            wrap_n = 1'b1;
            if (one_shot) done_n  = 1'b1;
            else          value_n = top;
          end else begin
            value_n = value - 1'b1;
          end
        end
        MODE_UPDOWN: begin
          // Top turnaround never terminates a one-shot; top==0 pins value at 0
          if (dir_reg && value >= top) begin
            wrap_n  = 1'b1;
            dir_n   = 1'b0;
            value_n = (value == '0) ? '0 : value - 1'b1;
          end else if (!dir_reg && value == '0) begin
            wrap_n = 1'b1;
            if (one_shot) begin
              done_n = 1'b1;
            end else begin
              dir_n   = 1'b1;
              value_n = (top == '0) ? '0 : value + 1'b1;
            end
          end else begin
            value_n = dir_reg ? value + 1'b1 : value - 1'b1;
          end
        end
        default: begin
          if (value >= top) begin
            wrap_n = 1'b1;
            if (one_shot) done_n  = 1'b1;
            else          value_n = '0;
          end else begin
            value_n = value + 1'b1;
          end
        end
      endcase
      match_n = (value_n == compare);
    end

    pwm_n = (value_n < compare);

    case (mode_e)
      MODE_DOWN:   direction_n = 1'b0;
      MODE_UPDOWN: direction_n = dir_n;
      default:     direction_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value     <= '0;
      p         <= '0;
      done      <= 1'b0;
      dir_reg   <= 1'b1;
      wrap      <= 1'b0;
      match     <= 1'b0;
      pwm       <= 1'b0;
      direction <= 1'b1;
    end else begin
      value     <= value_n;
      p         <= p_n;
      done      <= done_n;
      dir_reg   <= dir_n;
      wrap      <= wrap_n;
      match     <= match_n;
      pwm       <= pwm_n;
      direction <= direction_n;
    end
  end

endmodule

// File: tb/tb_timer_counter.sv
// Directed-vector bench for timer_counter with hand-computed expectations.
module tb_timer_counter;

  localparam int WIDTH = 16;
  localparam int PW    = 8;

  logic             clk = 1'b0;
  logic             rst, enable, halt, one_shot, load;
  logic [1:0]       mode;
  logic [PW-1:0]    prescale;
  logic [WIDTH-1:0] top, compare, load_value;
  logic [WIDTH-1:0] value;
  logic             direction, running, wrap, match, pwm;

  int vectors = 0;
  int fails   = 0;

  timer_counter #(.WIDTH(WIDTH), .PRESCALE_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .halt(halt), .mode(mode),
    .one_shot(one_shot), .prescale(prescale), .top(top), .compare(compare),
    .load(load), .load_value(load_value), .value(value),
    .direction(direction), .running(running), .wrap(wrap), .match(match),
    .pwm(pwm)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; enable = 1'b0; halt = 1'b0; one_shot = 1'b0; load = 1'b0;
    mode = 2'b00; prescale = '0; top = '0; compare = '0; load_value = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if (value !== 16'd0 || wrap !== 1'b0 || match !== 1'b0 || pwm !== 1'b0 ||
        direction !== 1'b1 || running !== 1'b0) begin
      fails++;
      $display("FAIL reset: value=%0d wrap=%b match=%b pwm=%b dir=%b run=%b, want 0 0 0 0 1 0",
               value, wrap, match, pwm, direction, running);
    end
  endtask

  task automatic test_up();
    int ev [6] = '{1, 2, 3, 4, 0, 1};
    bit ew [6] = '{0, 0, 0, 0, 1, 0};
    bit em [6] = '{0, 0, 1, 0, 0, 0};
    bit ep [6] = '{1, 1, 0, 0, 1, 1};
    apply_reset();
    enable = 1'b1; mode = 2'b00; top = 16'd4; compare = 16'd3;
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++;
      if (32'(value) !== ev[i] || wrap !== ew[i] || match !== em[i] || pwm !== ep[i] ||
          direction !== 1'b1) begin
        fails++;
        $display("FAIL up[%0d]: value=%0d wrap=%b match=%b pwm=%b dir=%b, want %0d %b %b %b 1",
                 i, value, wrap, match, pwm, direction, ev[i], ew[i], em[i], ep[i]);
      end
    end
  endtask

  task automatic test_down_prescale();
    int ev [15] = '{0, 0, 3, 3, 3, 2, 2, 2, 1, 1, 1, 0, 0, 0, 3};
    apply_reset();
    enable = 1'b1; mode = 2'b01; prescale = 8'd2; top = 16'd3;
    for (int i = 0; i < 15; i++) begin
      tick();
      vectors++;
      if (32'(value) !== ev[i] || wrap !== (i == 2 || i == 14) || direction !== 1'b0) begin
        fails++;
        $display("FAIL down[%0d]: value=%0d wrap=%b dir=%b, want %0d %b 0",
                 i, value, wrap, direction, ev[i], (i == 2 || i == 14));
      end
    end
  endtask

  task automatic test_updown();
    int ev [7] = '{1, 2, 3, 2, 1, 0, 1};
    bit ew [7] = '{0, 0, 0, 1, 0, 0, 1};
    bit em [7] = '{0, 1, 0, 1, 0, 0, 0};
    bit ep [7] = '{1, 0, 0, 0, 1, 1, 1};
    bit ed [7] = '{1, 1, 1, 0, 0, 0, 1};
    apply_reset();
    enable = 1'b1; mode = 2'b10; top = 16'd3; compare = 16'd2;
    for (int i = 0; i < 7; i++) begin
      tick();
      vectors++;
      if (32'(value) !== ev[i] || wrap !== ew[i] || match !== em[i] || pwm !== ep[i] ||
          direction !== ed[i]) begin
        fails++;
        $display("FAIL updown[%0d]: value=%0d wrap=%b match=%b pwm=%b dir=%b, want %0d %b %b %b %b",
                 i, value, wrap, match, pwm, direction, ev[i], ew[i], em[i], ep[i], ed[i]);
      end
    end
  endtask

  task automatic test_one_shot();
    int ev [4] = '{4, 5, 5, 5};
    bit ew [4] = '{0, 0, 1, 0};
    bit em [4] = '{1, 1, 1, 0};
    bit er [4] = '{1, 1, 0, 0};
    apply_reset();
    enable = 1'b1; mode = 2'b00; one_shot = 1'b1; top = 16'd5; compare = 16'd5;
    load = 1'b1; load_value = 16'd3;
    tick();
    load = 1'b0;
    vectors++;
    if (value !== 16'd3 || wrap !== 1'b0 || match !== 1'b0) begin
      fails++;
      $display("FAIL oneshot_load: value=%0d wrap=%b match=%b, want 3 0 0", value, wrap, match);
    end
    em[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (32'(value) !== ev[i] || wrap !== ew[i] || match !== em[i] || running !== er[i]) begin
        fails++;
        $display("FAIL oneshot[%0d]: value=%0d wrap=%b match=%b run=%b, want %0d %b %b %b",
                 i, value, wrap, match, running, ev[i], ew[i], em[i], er[i]);
      end
    end
    load = 1'b1; load_value = 16'd0;
    tick();
    load = 1'b0;
    vectors++;
    if (value !== 16'd0 || running !== 1'b1) begin
      fails++;
      $display("FAIL oneshot_reload: value=%0d run=%b, want 0 1", value, running);
    end
    tick();
    vectors++;
    if (value !== 16'd1 || wrap !== 1'b0) begin
      fails++;
      $display("FAIL oneshot_restart: value=%0d wrap=%b, want 1 0", value, wrap);
    end
  endtask

  task automatic test_halt();
    apply_reset();
    enable = 1'b1; mode = 2'b00; prescale = 8'd1; top = 16'd100; compare = 16'd0;
    for (int i = 0; i < 15; i++) tick();
    vectors++;
    if (value !== 16'd7) begin
      fails++;
      $display("FAIL halt_pre: value=%0d, want 7", value);
    end
    halt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (value !== 16'd7 || wrap !== 1'b0 || match !== 1'b0) begin
        fails++;
        $display("FAIL halt[%0d]: value=%0d wrap=%b match=%b, want 7 0 0", i, value, wrap, match);
      end
    end
    halt = 1'b0;
    tick();
    vectors++;
    if (value !== 16'd8) begin
      fails++;
      $display("FAIL halt_resume: value=%0d, want 8", value);
    end
    tick();
    enable = 1'b0;
    tick();
    vectors++;
    if (value !== 16'd8 || running !== 1'b0) begin
      fails++;
      $display("FAIL disable_hold: value=%0d run=%b, want 8 0", value, running);
    end
    enable = 1'b1;
    tick();
    vectors++;
    if (value !== 16'd8) begin
      fails++;
      $display("FAIL disable_clears_prescaler: value=%0d, want 8", value);
    end
    tick();
    vectors++;
    if (value !== 16'd9) begin
      fails++;
      $display("FAIL enable_resume: value=%0d, want 9", value);
    end
  endtask

  task automatic test_load_halt_top();
    apply_reset();
    enable = 1'b1; mode = 2'b00; top = 16'd100; compare = 16'd0;
    load = 1'b1; load_value = 16'd10;
    tick();
    halt = 1'b1; load_value = 16'd20; compare = 16'd20;
    tick();
    load = 1'b0; halt = 1'b0;
    vectors++;
    if (value !== 16'd20 || match !== 1'b0 || pwm !== 1'b0 || wrap !== 1'b0) begin
      fails++;
      $display("FAIL load_halt: value=%0d match=%b pwm=%b wrap=%b, want 20 0 0 0",
               value, match, pwm, wrap);
    end
    top = 16'd8;
    tick();
    vectors++;
    if (value !== 16'd0 || wrap !== 1'b1 || match !== 1'b0 || pwm !== 1'b1) begin
      fails++;
      $display("FAIL top_lowered: value=%0d wrap=%b match=%b pwm=%b, want 0 1 0 1",
               value, wrap, match, pwm);
    end
  endtask

  initial begin
    test_reset();
    test_up();
    test_down_prescale();
    test_updown();
    test_one_shot();
    test_halt();
    test_load_halt_top();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
